// File: rtl/seq_multdiv_pkg.sv
// Shared constants for the iterative multiply/divide unit and the execute-stage decode.
`default_nettype none

package seq_multdiv_pkg;

   typedef enum logic [2:0] {
      MD_IDLE = 3'd0,
      MD_MULT = 3'd1,
      MD_DIV  = 3'd2,
      MD_FIX  = 3'd3,
      MD_DONE = 3'd4
   } md_state_t;

   localparam int          MULT_ITERS = 16;
   localparam int          DIV_ITERS  = 32;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

   localparam logic [4:0]  ALU_OP_MUL = 5'b00110;
   localparam logic [4:0]  ALU_OP_DIV = 5'b00111;

endpackage

`default_nettype wire

// File: rtl/seq_multdiv_booth4_recode.sv
// Radix-4 modified Booth recoder: 3 overlapping multiplier bits -> {neg, two, zero} select.
`default_nettype none

module booth4_recode (
   input  logic [2:0] bits,
   output logic       neg,
   output logic       two,
   output logic       zero
);

   assign zero = (bits == 3'b000) | (bits == 3'b111);
   assign two  = (bits == 3'b011) | (bits == 3'b100);
   assign neg  = bits[2] & ~zero;

endmodule

`default_nettype wire

// File: rtl/seq_multdiv.sv
// Iterative signed multiply (radix-4 Booth, 16 steps) / divide (non-restoring, 32 steps) unit.
`default_nettype none

module seq_multdiv
   import seq_multdiv_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] DIVZERO_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam logic [4:0] MULT_LAST = 5'(MULT_ITERS - 1);
   localparam logic [4:0] DIV_LAST  = 5'(DIV_ITERS - 1);

   md_state_t        state, state_next;
   logic [4:0]       counter;
   logic             start;
   logic             op_div;

   // lo holds the multiplier during MULT (product low word at the end) and the
   // dividend magnitude during DIV (quotient magnitude at the end).
   logic [WIDTH+1:0] acc;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] opa;
   logic             qm1;
   logic             neg_q, div_zero, div_ovf;

   logic             neg, two, zero;
   logic [WIDTH+1:0] pp_mag, pp, sum;
   logic [WIDTH:0]   rem_sh, dvs, rem_new;
   logic [WIDTH:0]   prod_hi;
   logic             mult_ovf;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign start = ctrl_MULT | ctrl_DIV;

   booth4_recode u_recode (
      .bits ({lo[1:0], qm1}),
      .neg  (neg),
      .two  (two),
      .zero (zero)
   );

   always_comb begin
      pp_mag = '0;
      if (!zero) begin
         pp_mag = two ? {opa[WIDTH-1], opa, 1'b0} : {{2{opa[WIDTH-1]}}, opa};
      end
      pp  = neg ? -pp_mag : pp_mag;
      sum = acc + pp;
   end

   // Remainder may wrap mid-step; the true value always lands back in [-D, D).
   always_comb begin
      rem_sh  = {rem[WIDTH-1:0], lo[WIDTH-1]};
      dvs     = {1'b0, opa};
      rem_new = rem[WIDTH] ? (rem_sh + dvs) : (rem_sh - dvs);
   end

   assign prod_hi  = {acc[WIDTH-1:0], lo[WIDTH-1]};
   assign mult_ovf = ~((&prod_hi) | ~(|prod_hi));
   assign mag_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign mag_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= MD_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (start) begin
         state_next = ctrl_MULT ? MD_MULT : MD_DIV;
      end else begin
         unique case (state)
            MD_IDLE: state_next = MD_IDLE;
            MD_MULT: if (counter == MULT_LAST) state_next = MD_FIX;
            MD_DIV:  if (counter == DIV_LAST)  state_next = MD_FIX;
            MD_FIX:  state_next = MD_DONE;
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         counter        <= '0;
         op_div         <= 1'b0;
         acc            <= '0;
         rem            <= '0;
         lo             <= '0;
         opa            <= '0;
         qm1            <= 1'b0;
         neg_q          <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else if (start) begin
         counter        <= '0;
         acc            <= '0;
         rem            <= '0;
         qm1            <= 1'b0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         if (ctrl_MULT) begin
            op_div <= 1'b0;
            lo     <= data_operandB;
            opa    <= data_operandA;
         end else begin
            op_div   <= 1'b1;
            lo       <= mag_a;
            opa      <= mag_b;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
         end
      end else begin
         data_resultRDY <= 1'b0;
         unique case (state)
            MD_MULT: begin
               acc     <= {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
               lo      <= {sum[1:0], lo[WIDTH-1:2]};
               qm1     <= lo[1];
               counter <= counter + 5'd1;
            end
            MD_DIV: begin
               rem     <= rem_new;
               lo      <= {lo[WIDTH-2:0], ~rem_new[WIDTH]};
               counter <= counter + 5'd1;
            end
            MD_FIX: begin
               if (!op_div) begin
                  data_result    <= lo;
                  data_exception <= mult_ovf;
               end else if (div_zero) begin
                  data_result    <= DIVZERO_VAL;
                  data_exception <= 1'b1;
               end else if (div_ovf) begin
                  data_result    <= INT_MIN;
                  data_exception <= 1'b1;
               end else begin
                  data_result    <= neg_q ? -lo : lo;
                  data_exception <= 1'b0;
               end
            end
            MD_DONE: data_resultRDY <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
